// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO: owns the fetch PC and buffers imem words with PC+4 for decode.
// Optional macro FETCH_HALT_EN: stop fetching after an opcode-F word and expose a halted port.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          redirect,
  input  logic [5:0]    redirect_pc,
  output logic [5:0]    imem_addr,
  input  logic [15:0]   imem_data,
  input  logic          deq_ready,
  output logic          out_valid,
  output logic [15:0]   out_instr,
  output logic [5:0]    out_pcplus4,
`ifdef FETCH_HALT_EN
  output logic          halted,
`endif
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   r_instr [DEPTH];
  logic [5:0]    r_pcPlus4 [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [5:0]    r_fetchPc;

  logic       w_full;
  logic       w_deq;
  logic       w_enq;
  logic       w_stop;
  logic [5:0] w_nextPc;

`ifdef FETCH_HALT_EN
  logic r_halt;

  // Halt is raised by the opcode-F word itself, so that word still enters the queue.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_halt <= 1'b0;
    end else if (redirect) begin
      r_halt <= 1'b0;
    end else if (w_enq && (imem_data[15:12] == 4'hF)) begin
      r_halt <= 1'b1;
    end
  end

  assign w_stop = r_halt;
  assign halted = r_halt;
`else
  assign w_stop = 1'b0;
`endif

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_deq    = out_valid & deq_ready;
  assign w_enq    = (~w_full | w_deq) & ~w_stop;
  assign w_nextPc = r_fetchPc + 6'd4;

  assign imem_addr   = r_fetchPc;
  assign count       = r_count;
  assign out_valid   = (r_count != '0);
  // Empty queue reads as zero so unwritten entries never leak out.
  assign out_instr   = out_valid ? r_instr[r_head]   : 16'h0000;
  assign out_pcplus4 = out_valid ? r_pcPlus4[r_head] : 6'd0;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_fetchPc <= 6'd0;
    end else if (redirect) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_fetchPc <= redirect_pc;
    end else begin
      if (w_enq) begin
        r_tail    <= r_tail + 1'b1;
        r_fetchPc <= w_nextPc;
      end
      if (w_deq) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the empty-queue output forcing hides stale contents.
  always_ff @(posedge clk) begin
    if (!clear && !redirect && w_enq) begin
      r_instr[r_tail]   <= imem_data;
      r_pcPlus4[r_tail] <= w_nextPc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model plus directed and random stimulus.
// Honours FETCH_HALT_EN when the design is built with it.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  typedef struct {
    logic [15:0] instr;
    logic [5:0]  pcPlus4;
  } entry_t;

  logic          clk;
  logic          clear;
  logic          redirect;
  logic [5:0]    redirect_pc;
  logic [5:0]    imem_addr;
  logic [15:0]   imem_data;
  logic          deq_ready;
  logic          out_valid;
  logic [15:0]   out_instr;
  logic [5:0]    out_pcplus4;
  logic [CW-1:0] count;
`ifdef FETCH_HALT_EN
  logic          halted;
`endif

  logic [15:0] mem [64];
  entry_t      mq[$];
  logic [5:0]  mFetchPc;
  logic        mHalt;
  int          checks;
  int          failures;

  fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk         (clk),
    .clear       (clear),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .deq_ready   (deq_ready),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pcplus4 (out_pcplus4),
`ifdef FETCH_HALT_EN
    .halted      (halted),
`endif
    .count       (count)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: actual=%0h expected=%0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic clr, input logic redir, input logic [5:0] pc, input logic rdy);
    clear       = clr;
    redirect    = redir;
    redirect_pc = pc;
    deq_ready   = rdy;
  endtask

  // Reference model: a plain queue of fetched words, updated at every rising edge.
  always @(posedge clk) begin
    logic        doDeq;
    logic        doEnq;
    logic [15:0] word;
    entry_t      e;
    if (clear) begin
      mq.delete();
      mFetchPc = 6'd0;
      mHalt    = 1'b0;
    end else if (redirect) begin
      mq.delete();
      mFetchPc = redirect_pc;
      mHalt    = 1'b0;
    end else begin
      doDeq = (mq.size() != 0) && deq_ready;
      doEnq = ((mq.size() < DEPTH) || doDeq) && !mHalt;
      word  = mem[mFetchPc];
      if (doDeq) void'(mq.pop_front());
      if (doEnq) begin
        e.instr   = word;
        e.pcPlus4 = mFetchPc + 6'd4;
        mq.push_back(e);
        mFetchPc = mFetchPc + 6'd4;
`ifdef FETCH_HALT_EN
        if (word[15:12] == 4'hF) mHalt = 1'b1;
`endif
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    checkOutput("count", int'(count), mq.size());
    checkOutput("out_valid", int'(out_valid), (mq.size() != 0) ? 1 : 0);
    checkOutput("out_instr", int'(out_instr), (mq.size() != 0) ? int'(mq[0].instr) : 0);
    checkOutput("out_pcplus4", int'(out_pcplus4), (mq.size() != 0) ? int'(mq[0].pcPlus4) : 0);
    checkOutput("imem_addr", int'(imem_addr), int'(mFetchPc));
`ifdef FETCH_HALT_EN
    checkOutput("halted", int'(halted), int'(mHalt));
`endif
  end

  initial begin
    logic [5:0] a;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) begin
      a = 6'(i);
      mem[i] = {2'b01, a, 8'hA5};
    end
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);

    // Reset held for two edges.
    repeat (2) @(negedge clk);
    checkOutput("reset_valid", int'(out_valid), 0);
    checkOutput("reset_count", int'(count), 0);
    checkOutput("reset_addr", int'(imem_addr), 0);
    #1 applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);

    @(negedge clk);
    checkOutput("first_valid", int'(out_valid), 1);
    checkOutput("first_instr", int'(out_instr), 16'h40A5);
    checkOutput("first_pcplus4", int'(out_pcplus4), 4);

    // Stalled decode: queue fills to DEPTH and fetch stops at 16.
    repeat (4) @(negedge clk);
    checkOutput("fill_count", int'(count), 4);
    checkOutput("fill_addr", int'(imem_addr), 16);
    checkOutput("fill_head", int'(out_instr), 16'h40A5);
    #1 applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);

    @(negedge clk);
    checkOutput("stream_head4", int'(out_instr), 16'h44A5);
    checkOutput("stream_count", int'(count), 4);
    @(negedge clk);
    checkOutput("stream_head8", int'(out_instr), 16'h48A5);

    // Reach count=3, then redirect to 20.
    #1 applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    #1 applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("pre_redirect_count", int'(count), 3);
    #1 applyStimulus(1'b0, 1'b1, 6'd20, 1'b0);
    @(negedge clk);
    checkOutput("redirect_count", int'(count), 0);
    checkOutput("redirect_valid", int'(out_valid), 0);
    checkOutput("redirect_addr", int'(imem_addr), 20);
    #1 applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    checkOutput("redirect_instr", int'(out_instr), 16'h54A5);
    checkOutput("redirect_pcplus4", int'(out_pcplus4), 24);

    // PC wrap through 60 -> 0.
    #1 applyStimulus(1'b0, 1'b1, 6'd56, 1'b1);
    @(negedge clk);
    checkOutput("wrap_bubble", int'(out_valid), 0);
    checkOutput("wrap_addr", int'(imem_addr), 56);
    #1 applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    @(negedge clk);
    checkOutput("wrap_instr56", int'(out_instr), 16'h78A5);
    checkOutput("wrap_pcp60", int'(out_pcplus4), 60);
    @(negedge clk);
    checkOutput("wrap_instr60", int'(out_instr), 16'h7CA5);
    checkOutput("wrap_pcp0", int'(out_pcplus4), 0);
    @(negedge clk);
    checkOutput("wrap_instr0", int'(out_instr), 16'h40A5);
    checkOutput("wrap_pcp4", int'(out_pcplus4), 4);
    @(negedge clk);
    checkOutput("wrap_pcp8", int'(out_pcplus4), 8);

`ifdef FETCH_HALT_EN
    // Halt opcode at address 8: fetch freezes at 12 and the queue drains.
    #1 mem[8] = 16'hF000;
    applyStimulus(1'b0, 1'b1, 6'd0, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("halt_flag", int'(halted), 1);
    checkOutput("halt_addr", int'(imem_addr), 12);
    checkOutput("halt_count", int'(count), 0);
    #1 applyStimulus(1'b0, 1'b1, 6'd0, 1'b1);
    @(negedge clk);
    checkOutput("halt_cleared", int'(halted), 0);
    checkOutput("halt_restart_addr", int'(imem_addr), 0);
    #1 mem[8] = 16'h48A5;
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    @(negedge clk);
`endif

    // Random phase with random memory contents.
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      #1 applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                       6'($urandom_range(0, 63)), ($urandom_range(0, 9) < 7));
    end
    @(negedge clk);
    #1 applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
